// File: rtl/uart_rx_fe.sv
// uart_rx_fe: serial receive front end for the UART command path.
// Turns an asynchronous 8N1 line into bytes, each presented with a
// one-cycle strobe. It also flags framing errors and line-break conditions.
//
// Ports:
//   clk        in   system clock, rising-edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial input, idles high
//   rx_data    out  last correctly framed byte (LSB received first)
//   rx_ready   out  one-cycle strobe: rx_data updated this cycle
//   frame_err  out  one-cycle strobe: stop bit sampled low
//   rx_busy    out  high while a frame is being received
//   line_break out  high while the line is held low after a framing error
module uart_rx_fe #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       rx_busy,
    output logic       line_break
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_sync1, r_sync2;
    logic            w_rx_s;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [7:0]      r_data, w_data_nxt;
    logic            r_ready, w_ready_nxt;
    logic            r_ferr, w_ferr_nxt;
    logic            r_busy;

    assign w_rx_s     = r_sync2;
    assign rx_data    = r_data;
    assign rx_ready   = r_ready;
    assign frame_err  = r_ferr;
    assign rx_busy    = r_busy;
    assign line_break = (r_state == S_BREAK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_ready <= w_ready_nxt;
            r_ferr  <= w_ferr_nxt;
            // Registered from the current state so busy stays high through
            // the strobe cycle and drops on the cycle after it.
            r_busy  <= (r_state != S_IDLE);
        end
    end

    // The shift register needs no reset: it is only observed once a full
    // frame has been shifted in.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_ready_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt = '0;
                    // Leaving at mid stop bit leaves half a bit of margin
                    // for a back-to-back start bit.
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fe.sv
module tb_uart_rx_fe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx;
    logic       rx33;
    logic [7:0] rx_data, rx_data33;
    logic       rx_ready, rx_ready33;
    logic       frame_err, frame_err33;
    logic       rx_busy, rx_busy33;
    logic       line_break, line_break33;

    // 10 clocks per bit
    uart_rx_fe #(.CLK_FREQ(1000000), .BAUD(100000)) u_dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_ready(rx_ready), .frame_err(frame_err),
        .rx_busy(rx_busy), .line_break(line_break)
    );

    // 33 clocks per bit, driven at 32 and 34 clocks per bit
    uart_rx_fe #(.CLK_FREQ(3300000), .BAUD(100000)) u_dut33 (
        .clk(clk), .rst(rst), .rx(rx33),
        .rx_data(rx_data33), .rx_ready(rx_ready33), .frame_err(frame_err33),
        .rx_busy(rx_busy33), .line_break(line_break33)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       q10[$];
    exp_t       q33[$];
    exp_t       e10, e33;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last10;
    int         busy_cnt;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Drive one line level for n clocks; always returns 1 time unit after a rising edge.
    task automatic drive(input bit use33, input logic v, input int n);
        if (use33) rx33 = v;
        else       rx   = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int bp, input logic stopv, input bit use33);
        drive(use33, 1'b0, bp);
        for (int i = 0; i < 8; i++) drive(use33, b[i], bp);
        drive(use33, stopv, bp);
    endtask

    // Scoreboard monitors: pop and compare on every strobe.
    always @(negedge clk) begin
        if (rx_ready || frame_err) begin
            chk("dual_strobe10", 32'(rx_ready & frame_err), 0);
            if (q10.size() == 0) begin
                chk("unexpected_strobe10", 32'({rx_ready, frame_err}), 0);
            end else begin
                e10 = q10.pop_front();
                chk("strobe_err10", 32'(frame_err), 32'(e10.err));
                chk("strobe_ready10", 32'(rx_ready), 32'(!e10.err));
                chk("rx_data10", 32'(rx_data), 32'(e10.data));
            end
        end
    end

    always @(negedge clk) begin
        if (rx_ready33 || frame_err33) begin
            chk("dual_strobe33", 32'(rx_ready33 & frame_err33), 0);
            if (q33.size() == 0) begin
                chk("unexpected_strobe33", 32'({rx_ready33, frame_err33}), 0);
            end else begin
                e33 = q33.pop_front();
                chk("strobe_err33", 32'(frame_err33), 32'(e33.err));
                chk("strobe_ready33", 32'(rx_ready33), 32'(!e33.err));
                chk("rx_data33", 32'(rx_data33), 32'(e33.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        rx   = 1'b1;
        rx33 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 0);
        chk("reset_rx_ready", 32'(rx_ready), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        chk("reset_rx_busy", 32'(rx_busy), 0);
        chk("reset_line_break", 32'(line_break), 0);
        chk("reset_rx_busy33", 32'(rx_busy33), 0);
        chk("reset_line_break33", 32'(line_break33), 0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 10);

        // Good byte, with busy duration
        q10.push_back('{err: 1'b0, data: 8'hA3});
        last10 = 8'hA3;
        busy_cnt = 0;
        fork
            send(8'hA3, 10, 1'b1, 0);
            begin
                repeat (150) begin
                    @(negedge clk);
                    if (rx_busy) busy_cnt++;
                end
            end
        join
        chk("busy_len_93_97", 32'(busy_cnt >= 93 && busy_cnt <= 97), 1);
        @(posedge clk);
        #1;

        // Back-to-back bytes
        q10.push_back('{err: 1'b0, data: 8'h00});
        q10.push_back('{err: 1'b0, data: 8'hFF});
        q10.push_back('{err: 1'b0, data: 8'h55});
        last10 = 8'h55;
        send(8'h00, 10, 1'b1, 0);
        send(8'hFF, 10, 1'b1, 0);
        send(8'h55, 10, 1'b1, 0);
        drive(0, 1'b1, 20);

        // Glitch rejection
        drive(0, 1'b0, 3);
        busy_cnt = 0;
        fork
            drive(0, 1'b1, 30);
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (rx_busy) busy_cnt++;
                end
            end
        join
        chk("glitch_busy_pulse", 32'(busy_cnt > 0 && busy_cnt < 10), 1);
        chk("glitch_data_kept", 32'(rx_data), 32'(last10));
        @(posedge clk);
        #1;

        // Framing error, break, recovery
        q10.push_back('{err: 1'b1, data: last10});
        send(8'h3C, 10, 1'b0, 0);
        drive(0, 1'b0, 15);
        @(negedge clk);
        chk("break_high", 32'(line_break), 1);
        chk("break_busy", 32'(rx_busy), 1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 14);
        drive(0, 1'b1, 10);
        @(negedge clk);
        chk("break_cleared", 32'(line_break), 0);
        chk("ferr_data_kept", 32'(rx_data), 32'h55);
        @(posedge clk);
        #1;
        q10.push_back('{err: 1'b0, data: 8'h12});
        last10 = 8'h12;
        send(8'h12, 10, 1'b1, 0);
        drive(0, 1'b1, 20);

        // Reset during data bit 4 of 0x96; the sender abandons the frame too
        drive(0, 1'b0, 10);
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 10);
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        chk("midrst_rx_data", 32'(rx_data), 0);
        chk("midrst_rx_ready", 32'(rx_ready), 0);
        chk("midrst_frame_err", 32'(frame_err), 0);
        chk("midrst_rx_busy", 32'(rx_busy), 0);
        chk("midrst_line_break", 32'(line_break), 0);
        last10 = 8'h00;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 30);
        q10.push_back('{err: 1'b0, data: 8'h69});
        last10 = 8'h69;
        send(8'h69, 10, 1'b1, 0);
        drive(0, 1'b1, 20);
        chk("after_reset_data", 32'(rx_data), 32'h69);

        // Baud tolerance on the 33 clk/bit instance
        q33.push_back('{err: 1'b0, data: 8'h5A});
        send(8'h5A, 32, 1'b1, 1);
        drive(1, 1'b1, 40);
        q33.push_back('{err: 1'b0, data: 8'h5A});
        send(8'h5A, 34, 1'b1, 1);
        drive(1, 1'b1, 60);

        chk("q10_drained", 32'(q10.size()), 0);
        chk("q33_drained", 32'(q33.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
